ssd_display_driver: RTL and testbench
=====================================

Name: ssd_display_driver

Overview:
- Drives the 4-digit multiplexed seven-segment display from the CPU's 13-bit SSD_out debug value.
- Sequentially converts the binary value to 4 BCD digits using iterative double-dabble, one shift per clock.
- Time-multiplexes the digits onto active-low anodes and cathodes.
- Sits at board top level between the CPU's SSD_out and the FPGA display pins.

Parameters:
- REFRESH_DIV, 100000, clocks per digit slot; must be >= 1. Benches use 4.
- NUM_BITS, 13, width of value_in. Fixed 4 digits, so max value is 8191.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- value_in  input  13  binary value to display (CPU SSD_out)
- blank_lz  input  1  1 = blank leading zero digits
- anode  output  4  digit enables, active-low; anode[0] = ones digit
- cathode  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; constant 1 (off)
- bcd  output  16  latched BCD {thousands,hundreds,tens,ones}
- busy  output  1  conversion in progress
- valid  output  1  bcd holds at least one completed conversion

Behaviour:
- Reset values: anode=4'b1111, cathode=7'b1111111, dp=1, bcd=0, busy=0, valid=0.
- Reset also clears: FSM to IDLE, refresh counter=0, digit index=0, held value=0, force flag=1.
- Reset mid-conversion aborts the conversion. No partial bcd update occurs.
- FSM states are IDLE, CONV.
- IDLE: at edge E0, if (value_in != held value) or force flag is set:
  - held value <= value_in; shift register <= {16'b0, value_in}; bit counter <= 13.
  - force flag <= 0; busy <= 1; go to CONV.
  - Otherwise stay in IDLE.
- CONV: each edge, every BCD nibble >= 5 gets +3, then the whole {bcd,bin} register shifts left by 1.
  - Bit counter decrements each edge.
  - At the 13th shift (E13): bcd <= converted digits, valid <= 1, busy <= 0, go to IDLE.
  - A new change can be sampled at E14 at the earliest.
- Latency: bcd updates exactly 13 clocks after the sampling edge; busy is high for exactly 13 cycles.
- value_in changes while busy are ignored during CONV. They are caught at the first IDLE edge because the compare uses the held value. Intermediate values may be skipped.
- bcd changes only at conversion completion, so the display never shows partial digits.
- Refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index increments mod 4 (3 -> 0).
- anode and cathode are registered: they reflect the digit index and bcd from the previous cycle (1-cycle latency).
- Exactly one anode bit is low when valid=1. All anodes stay high while valid=0.
- Segment codes (cathode), digits 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Blank = 1111111. Nibble values > 9 are unreachable; they map to blank.
- Leading-zero blanking (blank_lz=1):
  - Digit k in 1..3 is blanked (anode still driven low, cathode=blank) when digits k..3 are all zero.
  - Digit 0 is never blanked.
- blank_lz is sampled combinationally into the registered cathode path.

Decomposition:
- Package ssd_pkg holds:
  - state enum {IDLE, CONV};
  - SEG_DIGIT[0:9] constant array and SEG_BLANK;
  - ANODE_OFF constant;
  - NUM_DIGITS=4.
- Sub-module bin2bcd_seq contains the conversion FSM, shift register and bit counter.
  - Ports: clk, rst, bin, start, bcd, busy, done.
- Top ssd_display_driver holds change detection, the refresh counter and the scan/segment output registers.

Test Plan:
- Reset then value_in=0, REFRESH_DIV=4: busy high for exactly 13 cycles; valid rises with bcd=16'h0000. Anodes then cycle 1110,1101,1011,0111 every 4 clocks. With blank_lz=1, cathode=1000000 on digit 0 and 1111111 on digits 1-3.
- value_in=13'd8191: bcd=16'h8191 13 clocks after sampling. Scan shows cathodes 1111001 (1), 0010000 (9), 1111001 (1), 0000000 (8) for anode[0]..anode[3].
- value_in=1234 held, then changed to 42 on the 5th busy cycle: first result is bcd=16'h1234. A second conversion starts at the next IDLE edge and gives bcd=16'h0042. With blank_lz=1, anode[3:2] show blank; with blank_lz=0 they show 1000000.
- Assert rst on the 7th CONV cycle of value 999: outputs return to reset values immediately, with bcd=0 and valid=0. After release a forced conversion of the current value_in occurs.
- value_in constant 305 for 200 cycles after the first conversion: busy pulses exactly once. bcd stays 16'h0305, and with blank_lz=1 digit 3 is blanked while digit 1 (0) is shown.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and segment constants for the seven-segment display driver
// Contents: conversion FSM state enum, segment code table, blank/anode-off
// constants, digit count, and a nibble-to-segment helper.
package ssd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Non-decimal nibbles cannot come out of the converter; show them as blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    if (nib <= 4'd9) return SEG_DIGIT[nib];
    else return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to 4-digit BCD converter
// Ports: clk, rst (sync active-high), bin (binary input), start (sampled in IDLE),
//        bcd (latched result, updated only on completion), busy (conversion
//        in progress), done (strobe during the final shift cycle).
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int NUM_BITS = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] bin,
  input  logic                start,
  output logic [15:0]         bcd,
  output logic                busy,
  output logic                done
);

  localparam int SW = 16 + NUM_BITS;
  localparam int CW = $clog2(NUM_BITS + 1);

  state_t          state;
  logic [SW-1:0]   shreg;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   shifted;
  logic [CW-1:0]   bit_cnt;

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    adj = shreg;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (shreg[NUM_BITS+4*d +: 4] >= 4'd5)
        adj[NUM_BITS+4*d +: 4] = shreg[NUM_BITS+4*d +: 4] + 4'd3;
    end
  end

  assign shifted = {adj[SW-2:0], 1'b0};

  // Combinational so the parent can flag its result valid on the same edge
  // that loads bcd.
  assign done = (state == CONV) && (bit_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= {16'b0, bin};
            bit_cnt <= CW'(NUM_BITS);
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          shreg   <= shifted;
          bit_cnt <= bit_cnt - 1'b1;
          if (done) begin
            bcd   <= shifted[SW-1:NUM_BITS];
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ssd_display_driver.sv
// rtl/ssd_display_driver.sv - 4-digit multiplexed seven-segment driver with sequential BCD conversion
// Ports: clk, rst (sync active-high), value_in (binary value), blank_lz
//        (leading-zero blanking), anode/cathode/dp (active-low display pins),
//        bcd (latched digits), busy (converting), valid (bcd holds a result).
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_BITS    = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] value_in,
  input  logic                blank_lz,
  output logic [3:0]          anode,
  output logic [6:0]          cathode,
  output logic                dp,
  output logic [15:0]         bcd,
  output logic                busy,
  output logic                valid
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_TC = RW'(REFRESH_DIV - 1);

  logic [NUM_BITS-1:0] held;
  logic                force_conv;
  logic                start;
  logic                conv_done;
  logic [RW-1:0]       ref_cnt;
  logic [1:0]          digit_idx;
  logic [3:0]          cur_nib;
  logic                lz_blank;

  // busy is low exactly when the converter sits in IDLE, so start is only
  // ever honoured there; changes during CONV are caught on the first idle
  // edge because the compare is against the held value.
  assign start = !busy && ((value_in != held) || force_conv);

  bin2bcd_seq #(.NUM_BITS(NUM_BITS)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .bin   (value_in),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (conv_done)
  );

  assign dp = 1'b1;

  // Digit k>0 is a leading zero when it and every digit above it is zero.
  always_comb begin
    cur_nib  = bcd[{digit_idx, 2'b00} +: 4];
    lz_blank = 1'b0;
    case (digit_idx)
      2'd1:    lz_blank = blank_lz && (bcd[15:4] == 12'h000);
      2'd2:    lz_blank = blank_lz && (bcd[15:8] == 8'h00);
      2'd3:    lz_blank = blank_lz && (bcd[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held       <= '0;
      force_conv <= 1'b1;
      valid      <= 1'b0;
      ref_cnt    <= '0;
      digit_idx  <= 2'd0;
      anode      <= ANODE_OFF;
      cathode    <= SEG_BLANK;
    end else begin
      if (start) begin
        held       <= value_in;
        force_conv <= 1'b0;
      end
      if (conv_done) valid <= 1'b1;

      if (ref_cnt == REF_TC) begin
        ref_cnt   <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end

      if (valid) begin
        anode   <= ~(4'b0001 << digit_idx);
        cathode <= lz_blank ? SEG_BLANK : seg_encode(cur_nib);
      end else begin
        anode   <= ANODE_OFF;
        cathode <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_ssd_display_driver.sv
// tb/tb_ssd_display_driver.sv - randomized self-checking bench for ssd_display_driver
module tb_ssd_display_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] value_in = '0;
  logic        blank_lz = 1'b1;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic [15:0] bcd;
  logic        busy;
  logic        valid;

  int vectors = 0;
  int miscompares = 0;

  ssd_display_driver #(.REFRESH_DIV(DIV), .NUM_BITS(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .blank_lz (blank_lz),
    .anode    (anode),
    .cathode  (cathode),
    .dp       (dp),
    .bcd      (bcd),
    .busy     (busy),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  int p10 [0:3] = '{1, 10, 100, 1000};

  // Reference model: conversion as a countdown plus decimal arithmetic.
  int         m_left, m_dec, m_pend, m_held, m_ref, m_dig;
  bit         m_force, m_valid;
  logic [3:0] m_anode;
  logic [6:0] m_cath;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    int dg;
    bit blank;
    if (rst) begin
      m_left = 0; m_dec = 0; m_pend = 0; m_held = 0; m_ref = 0; m_dig = 0;
      m_force = 1; m_valid = 0; m_anode = 4'b1111; m_cath = 7'b1111111;
      return;
    end
    if (m_valid) begin
      dg    = (m_dec / p10[m_dig]) % 10;
      blank = blank_lz && (m_dig > 0) && (m_dec < p10[m_dig]);
      m_anode = 4'b1111;
      m_anode[m_dig] = 1'b0;
      m_cath = blank ? 7'b1111111 : seg_tab[dg];
    end else begin
      m_anode = 4'b1111;
      m_cath  = 7'b1111111;
    end
    if (m_ref == DIV - 1) begin
      m_ref = 0;
      m_dig = (m_dig + 1) % 4;
    end else begin
      m_ref++;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_dec   = m_pend;
        m_valid = 1;
      end
    end else if ((int'(value_in) != m_held) || m_force) begin
      m_held  = int'(value_in);
      m_pend  = int'(value_in);
      m_force = 0;
      m_left  = 13;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("anode", 32'(anode), 32'(m_anode));
    check("cathode", 32'(cathode), 32'(m_cath));
    check("dp", 32'(dp), 32'd1);
    check("bcd", 32'(bcd), 32'(to_bcd(m_dec)));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("valid", 32'(valid), 32'(m_valid));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int pulses;
    logic prev_busy;

    // Reset, then value 0 with leading-zero blanking.
    rst = 1'b1; value_in = 13'd0; blank_lz = 1'b1;
    run(3);
    rst = 1'b0;
    run(40);

    // Maximum value.
    value_in = 13'd8191;
    run(50);

    // Change to 42 on the 5th busy cycle of 1234; both results must appear.
    value_in = 13'd1234;
    run(5);
    value_in = 13'd42;
    run(50);
    check("bcd_42", 32'(bcd), 32'h0042);
    blank_lz = 1'b0;
    run(30);
    blank_lz = 1'b1;

    // Reset on the 7th CONV cycle of 999, then a forced reconversion.
    value_in = 13'd999;
    run(7);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(40);
    check("bcd_999", 32'(bcd), 32'h0999);

    // Constant 305: exactly one conversion over 200 cycles.
    value_in = 13'd305;
    pulses = 0;
    prev_busy = busy;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (busy && !prev_busy) pulses++;
      prev_busy = busy;
    end
    check("busy_pulses_305", 32'(pulses), 32'd1);
    check("bcd_305", 32'(bcd), 32'h0305);

    // Random value changes, blanking toggles and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) value_in = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
